// File: rtl/video_dram_arb.sv
// DRAM slot arbiter: splits DRAM cycles (one per cend) between video fetch, CPU and optional refresh.
// Optional refresh support is compiled in with `define VIDEO_ARB_REFRESH_EN.
module video_dram_arb #(
  parameter int RD_LAT  = 2,
  parameter int REF_PER = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cend,
  input  logic        go,
  input  logic [1:0]  bw,
  input  logic [20:0] video_addr,
  output logic        video_next,
  output logic        video_strobe,
  output logic [15:0] video_data,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [20:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_next,
  output logic        cpu_strobe,
  output logic [15:0] cpu_rdata,
  output logic        dram_req,
  output logic        dram_rnw,
  output logic [20:0] dram_addr,
  output logic [15:0] dram_wdata,
  output logic        dram_rfsh,
  input  logic [15:0] dram_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_V    = 2'd1,
    TAG_C    = 2'd2
  } tag_t;

  if (RD_LAT < 1 || RD_LAT > 4 || REF_PER < 2) begin : g_param_check
    $error("video_dram_arb: RD_LAT must be 1..4 and REF_PER at least 2");
  end

  logic [1:0]  r_phase;
  logic        r_go_d;
  logic        r_dram_req;
  logic        r_dram_rnw;
  logic [20:0] r_dram_addr;
  logic [15:0] r_dram_wdata;
  tag_t        r_tag [RD_LAT];

  logic [1:0]  w_phase;
  logic        w_slot_v;
  logic        w_ref_pend;
  logic        w_grant_v;
  logic        w_grant_c;
  tag_t        w_push;

  // A fresh go restarts the slot pattern so video always gets the first slot.
  assign w_phase = (go && !r_go_d) ? 2'd0 : r_phase;

  always_comb begin
    w_slot_v = 1'b0;
    if (go) begin
      if (bw[1])      w_slot_v = 1'b1;
      else if (bw[0]) w_slot_v = ~w_phase[0];
      else            w_slot_v = (w_phase == 2'd0);
    end
  end

  assign w_grant_v = cend & w_slot_v;
  assign w_grant_c = cend & ~w_slot_v & ~w_ref_pend & cpu_req;

  always_comb begin
    w_push = TAG_NONE;
    if (w_grant_v)                 w_push = TAG_V;
    else if (w_grant_c && cpu_rnw) w_push = TAG_C;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= 2'd0;
      r_go_d       <= 1'b0;
      r_dram_req   <= 1'b0;
      r_dram_rnw   <= 1'b0;
      r_dram_addr  <= 21'd0;
      r_dram_wdata <= 16'd0;
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= TAG_NONE;
    end else if (cend) begin
      r_phase    <= w_phase + 2'd1;
      r_go_d     <= go;
      r_dram_req <= w_grant_v | w_grant_c;
      if (w_grant_v) begin
        r_dram_rnw  <= 1'b1;
        r_dram_addr <= video_addr;
      end else if (w_grant_c) begin
        r_dram_rnw   <= cpu_rnw;
        r_dram_addr  <= cpu_addr;
        r_dram_wdata <= cpu_wdata;
      end
      r_tag[0] <= w_push;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

`ifdef VIDEO_ARB_REFRESH_EN
  localparam int CW = $clog2(REF_PER);

  logic [CW-1:0] r_ref_cnt;
  logic          r_ref_pend;
  logic          r_dram_rfsh;
  logic          w_grant_r;

  assign w_ref_pend = r_ref_pend;
  assign w_grant_r  = cend & ~w_slot_v & r_ref_pend;

  // A wrap while a refresh is still pending just re-sets the flag; there is no backlog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt   <= '0;
      r_ref_pend  <= 1'b0;
      r_dram_rfsh <= 1'b0;
    end else if (cend) begin
      r_dram_rfsh <= w_grant_r;
      if (r_ref_cnt == CW'(REF_PER - 1)) begin
        r_ref_cnt  <= '0;
        r_ref_pend <= 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
        if (w_grant_r) r_ref_pend <= 1'b0;
      end
    end
  end

  assign dram_rfsh = r_dram_rfsh;
`else
  assign w_ref_pend = 1'b0;
  assign dram_rfsh  = 1'b0;
`endif

  assign video_next   = w_grant_v;
  assign cpu_next     = w_grant_c;
  assign video_strobe = cend & (r_tag[RD_LAT-1] == TAG_V);
  assign cpu_strobe   = cend & (r_tag[RD_LAT-1] == TAG_C);
  assign video_data   = dram_rdata;
  assign cpu_rdata    = dram_rdata;
  assign dram_req     = r_dram_req;
  assign dram_rnw     = r_dram_rnw;
  assign dram_addr    = r_dram_addr;
  assign dram_wdata   = r_dram_wdata;

endmodule
